// File: rtl/mult32_seq.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned.
// Sign is stripped on entry and restored on the product in a final SIGN step.
module mult32_seq #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SIGN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0]   r_amag;
    logic               r_c;
    logic [WIDTH-1:0]   r_phi;
    logic [WIDTH-1:0]   r_plo;
    logic               r_neg;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_load;
    logic               w_iter;
    logic               w_fin;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_res;

    // The most negative operand negates to itself, which read unsigned is exact.
    assign w_a_neg = SIGNED & A[WIDTH-1];
    assign w_b_neg = SIGNED & B[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~A + WIDTH'(1)) : A;
    assign w_b_mag = w_b_neg ? (~B + WIDTH'(1)) : B;

    assign w_sum  = r_plo[0] ? ({1'b0, r_phi} + {1'b0, r_amag})
                             : {r_c, r_phi};
    assign w_prod = {r_phi, r_plo};
    assign w_res  = r_neg ? (~w_prod + (2*WIDTH)'(1)) : w_prod;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_iter      = 1'b0;
        w_fin       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_iter = 1'b1;
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_state_nxt = S_SIGN;
                end
            end
            S_SIGN: begin
                w_fin       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_amag <= '0;
            r_c    <= 1'b0;
            r_phi  <= '0;
            r_plo  <= '0;
            r_neg  <= 1'b0;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_fin;
            if (w_load) begin
                r_amag <= w_a_mag;
                r_c    <= 1'b0;
                r_phi  <= '0;
                r_plo  <= w_b_mag;
                r_neg  <= w_a_neg ^ w_b_neg;
                r_cnt  <= '0;
            end
            if (w_iter) begin
                {r_c, r_phi, r_plo} <= {1'b0, w_sum, r_plo[WIDTH-1:1]};
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_fin) begin
                {r_hi, r_lo} <= w_res;
            end
        end
    end

    assign HI   = r_hi;
    assign LO   = r_lo;
    assign DONE = r_done;
    assign BUSY = (r_state == S_CALC) || (r_state == S_SIGN);

endmodule
